display_scan_ctrl: RTL
======================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter N, default 10, SHALL set the binary input width; legal range 4..13.
REQ-002 Parameter DIV, default 50000, SHALL set clk cycles per digit refresh slot; legal range >= 2.
REQ-003 Parameter BLANK_LZ, default 1, SHALL enable leading-zero blanking when 1.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 value_in  in  N  SHALL be the unsigned binary value to convert, sampled only when a load is accepted.
REQ-007 load  in  1  SHALL request conversion of value_in.
REQ-008 busy  out  1  SHALL be high while a conversion is in progress.
REQ-009 done  out  1  SHALL be a one-cycle pulse marking bcd_out update.
REQ-010 bcd_out  out  16  SHALL be the displayed digits {thousands, hundreds, tens, units}, 4 bits each.
REQ-011 seg  out  7  SHALL be the shared segment bus {g,f,e,d,c,b,a}, active-low.
REQ-012 an  out  4  SHALL be the digit enables, active-low one-hot; an[0] units ... an[3] thousands.

Function
REQ-013 The conversion FSM SHALL have states IDLE, SHIFT, DONE.
REQ-014 In IDLE with load=1, the block SHALL capture value_in, clear the BCD accumulator, load the shift counter with N, and enter SHIFT.
REQ-015 load SHALL be ignored in SHIFT and DONE; no queuing of requests.
REQ-016 Each SHIFT cycle SHALL add 3 to every BCD nibble >= 5 and then shift {BCD, binary} left by one (double dabble).
REQ-017 After exactly N SHIFT cycles the FSM SHALL enter DONE; in DONE for one cycle, then return to IDLE.
REQ-018 bcd_out SHALL update on the edge entering DONE and hold until the next DONE; done=1 exactly in DONE, busy=1 exactly in SHIFT.
REQ-019 Latency: load sampled at edge k -> busy high for cycles k+1..k+N, done high for cycle k+N+1, IDLE again at k+N+2.
REQ-020 A free-running prescaler SHALL count 0..DIV-1 and wrap; on wrap the digit index SHALL advance 0->1->2->3->0.
REQ-021 an SHALL be all-ones except bit [index] low; seg SHALL be the encoding of the selected bcd_out nibble; both registered.
REQ-022 Encoding (seg, g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; nibbles 10-15 SHALL drive 1111111.
REQ-023 With BLANK_LZ=1: thousands blank if 0; hundreds blank if thousands and hundreds 0; tens blank if upper three digits 0; units never blank; blank = seg 1111111, an still asserted.
REQ-024 Scanning SHALL continue unaffected during conversion, displaying the previous bcd_out.

Reset
REQ-025 rst=1 SHALL immediately force: FSM IDLE, busy=0, done=0, bcd_out=0x0000, prescaler=0, index=0, an=1110, seg=1000000.
REQ-026 Reset during SHIFT SHALL abandon the conversion; no done pulse, bcd_out remains 0x0000.

Verification (DIV=4 for simulation)
REQ-027 Assert rst -> an=1110, seg=1000000, bcd_out=0x0000, busy=0, done=0 without a clock edge.
REQ-028 N=10, load with value_in=1023 -> busy high 10 cycles, done one cycle later, bcd_out=0x1023, done never re-asserts.
REQ-029 BLANK_LZ=1, convert 7 -> an cycles 1110,1101,1011,0111, each held 4 cycles; seg=1111000 on an=1110, 1111111 on the other three.
REQ-030 Convert 500, then pulse load with value_in=5 in the third busy cycle -> ignored; bcd_out=0x0500, exactly one done.
REQ-031 rst at 5th busy cycle of a 999 conversion -> busy=0, bcd_out=0x0000; then convert 100 -> bcd_out=0x0100, tens digit shows 1000000 (not blanked).
REQ-032 N=13, convert 8191 -> busy 13 cycles, bcd_out=0x8191.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: converts an N-bit binary value to four BCD digits
// (shift-and-add-3) and multiplexes them onto a shared, active-low
// 7-segment bus with optional leading-zero blanking.
module display_scan_ctrl #(
  parameter int N        = 10,
  parameter int DIV      = 50000,
  parameter int BLANK_LZ = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] value_in,
  input  logic         load,
  output logic         busy,
  output logic         done,
  output logic [15:0]  bcd_out,
  output logic [6:0]   seg,
  output logic [3:0]   an
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int             PW        = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);
  localparam logic [3:0]     N_CNT     = 4'(N);
  localparam logic [6:0]     SEG_BLANK = 7'b1111111;

  // Segment pattern {g,f,e,d,c,b,a}, active-low; non-decimal nibbles go dark.
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------
  // Conversion datapath
  // ---------------------------------------------------------------------
  state_t         state_reg, state_next;
  logic [N-1:0]   bin_reg, bin_next;
  logic [15:0]    acc_reg, acc_next;
  logic [3:0]     cnt_reg, cnt_next;
  logic [15:0]    bcd_reg;
  logic [15:0]    acc_adj;
  logic [15:0]    acc_shift;
  logic [N-1:0]   bin_shift;

  // Add-3 correction on every nibble that would overflow past 9 once doubled.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign acc_adj[gi*4 +: 4] = (acc_reg[gi*4 +: 4] >= 4'd5) ?
                                  acc_reg[gi*4 +: 4] + 4'd3 :
                                  acc_reg[gi*4 +: 4];
    end
  endgenerate

  assign acc_shift = {acc_adj[14:0], bin_reg[N-1]};
  assign bin_shift = {bin_reg[N-2:0], 1'b0};

  // State, shift register and counter update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: requests are only accepted from IDLE.
  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (load) begin
          bin_next   = value_in;
          acc_next   = '0;
          cnt_next   = N_CNT;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        bin_next = bin_shift;
        acc_next = acc_shift;
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Publish the result on the edge that enters DONE (last shift's output).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     bcd_reg <= '0;
    else if (state_reg == SHIFT && cnt_reg == 4'd1) bcd_reg <= acc_shift;
  end

  assign busy    = (state_reg == SHIFT);
  assign done    = (state_reg == DONE);
  assign bcd_out = bcd_reg;

  // ---------------------------------------------------------------------
  // Display scanning
  // ---------------------------------------------------------------------
  logic [PW-1:0] presc_reg;
  logic [1:0]    idx_reg;
  logic [3:0]    dig_zero;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    seg_reg, seg_next;
  logic [3:0]    an_reg, an_next;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_zero
      assign dig_zero[gi] = (bcd_reg[gi*4 +: 4] == 4'd0);
    end
  endgenerate

  // Free-running slot timer; each wrap moves to the next digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
      idx_reg   <= '0;
    end else if (presc_reg == PRESC_MAX) begin
      presc_reg <= '0;
      idx_reg   <= idx_reg + 2'd1;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  // Pick the current digit and decide whether it is a leading zero.
  always_comb begin
    nib   = bcd_reg[{idx_reg, 2'b00} +: 4];
    blank = 1'b0;
    if (BLANK_LZ != 0) begin
      case (idx_reg)
        2'd3:    blank = dig_zero[3];
        2'd2:    blank = dig_zero[3] & dig_zero[2];
        2'd1:    blank = dig_zero[3] & dig_zero[2] & dig_zero[1];
        default: blank = 1'b0;
      endcase
    end
    seg_next = blank ? SEG_BLANK : seg_enc(nib);
    an_next  = ~(4'b0001 << idx_reg);
  end

  // Register the drive pins so they change together and glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_reg <= 7'b1000000;
      an_reg  <= 4'b1110;
    end else begin
      seg_reg <= seg_next;
      an_reg  <= an_next;
    end
  end

  assign seg = seg_reg;
  assign an  = an_reg;

endmodule
